boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, meaning bits per ROM word (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning ROM address width.
REQ-003 SHALL have parameter FLASH_BASE, default 24'h100000, meaning flash byte address of the image header.
REQ-004 SHALL have parameter SCK_DIV, default 2, meaning CLK cycles per FLASH_SCK half-period (>=1).
REQ-005 SHALL have port CLK, input, 1, system clock.
REQ-006 SHALL have port RST_N, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, re-boot request, rising-edge detected.
REQ-008 SHALL have ports FLASH_SCK, FLASH_SSB, FLASH_IO0 (outputs, 1 bit each) and FLASH_IO1 (input, 1 bit): SPI clock, select (active low), MOSI, MISO.
REQ-009 SHALL have outputs rom_addr [ADDR_WIDTH], rom_data [WORD_WIDTH] and rom_load [1]: the ROM write port.
REQ-010 SHALL have outputs cpu_hold, busy, done and error, each 1 bit: CPU stall, transfer active, image loaded, load failed.

Function
REQ-011 SHALL implement the states IDLE, CMD, ADDR, HDR, DATA, CSUM, FINISH, DONE and ERROR.
REQ-012 SHALL enter CMD on the first CLK after RST_N deasserts, with no start pulse needed.
REQ-013 SHALL pull FLASH_SSB low on entry to CMD and shift out 8'h03, then FLASH_BASE as 24 bits, MSB first; SPI mode 0.
REQ-014 SHALL change FLASH_IO0 only while FLASH_SCK is low, and SHALL sample FLASH_IO1 on each FLASH_SCK rising edge.
REQ-015 SHALL generate FLASH_SCK with SCK_DIV CLK cycles high and SCK_DIV CLK cycles low.
REQ-016 SHALL read in HDR one WORD_WIDTH-bit length word N, big-endian bytes.
REQ-017 SHALL go to ERROR if N > 2^ADDR_WIDTH; if N = 0 it SHALL skip DATA.
REQ-018 SHALL assemble N words in DATA.
- Each word: a one-cycle rom_load pulse, with rom_addr/rom_data valid in that cycle.
- Pulse in the CLK cycle after the word's last bit is sampled.
- Addresses 0..N-1 ascending; addr N-1 = 2^ADDR_WIDTH-1 SHALL NOT wrap or write again.
REQ-019 SHALL, in FINISH, raise FLASH_SSB, hold it high for at least 2*SCK_DIV cycles, then enter DONE.
REQ-020 SHALL hold in DONE: busy=0, done=1, cpu_hold=0, FLASH_SSB=1, FLASH_SCK=0.
REQ-021 SHALL hold in ERROR: busy=0, error=1, cpu_hold=1, FLASH_SSB=1.
REQ-022 SHALL hold cpu_hold=1 and busy=1 in every state from CMD through FINISH.
REQ-023 SHALL treat a start rising edge in DONE or ERROR as a re-boot.
- Clears done/error.
- Asserts cpu_hold in the next cycle.
- Enters CMD.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL drive rom_load low in every state except the DATA write cycle.

Reset
REQ-026 SHALL, while RST_N=0, immediately force the state to IDLE and set:
- FLASH_SSB=1, FLASH_SCK=0, FLASH_IO0=0
- rom_load=0, rom_addr=0, rom_data=0
- cpu_hold=1, busy=0, done=0, error=0
REQ-027 SHALL abandon any transfer when reset is asserted mid-operation; the next boot restarts from header.

Configuration
REQ-028 SHALL compile in checksum verification when BOOT_CHECKSUM_EN is defined.
- Read one extra word C in CSUM, after DATA.
- Go to ERROR (via SSB high) unless C + sum(N, all data words) mod 2^WORD_WIDTH = 0.
REQ-029 SHALL, without BOOT_CHECKSUM_EN, have no CSUM state, read no trailing word and go from DATA to FINISH.

Verification
REQ-030 SHALL verify: SPI flash model holding N=3 and words 16'h0001, 16'h00FF, 16'hA5A5 -> exactly 3 rom_load pulses (addr 0, 1, 2 with those data), then done=1, cpu_hold=0.
REQ-031 SHALL verify: N=0 -> no rom_load, done=1; FLASH_SSB high for >=4 CLK (SCK_DIV=2) before done.
REQ-032 SHALL verify: N=16385 with ADDR_WIDTH=14 -> no rom_load, error=1, cpu_hold=1.
REQ-033 SHALL verify: RST_N low during the 2nd data word -> FLASH_SSB=1 within the same cycle; after release, a full reload from addr 0.
REQ-034 SHALL verify, with BOOT_CHECKSUM_EN, N=2, data 16'h0010, 16'h0020:
- C=16'hFFCE -> done=1.
- C=16'hFFCF -> error=1.
- Then a start pulse with C corrected -> done=1.
REQ-035 SHALL verify: first command bits on FLASH_IO0 are 0x03,0x10,0x00,0x00 MSB first, stable on each FLASH_SCK rising edge.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: copies a length-prefixed image from SPI flash (READ 0x03) into the CPU ROM,
// stalling the CPU until the load completes. Define BOOT_CHECKSUM_EN to verify a trailing checksum word.
module boot_loader #(
   parameter int          WORD_WIDTH = 16,
   parameter int          ADDR_WIDTH = 14,
   parameter logic [23:0] FLASH_BASE = 24'h100000,
   parameter int          SCK_DIV    = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  start,
   output logic                  FLASH_SCK,
   output logic                  FLASH_SSB,
   output logic                  FLASH_IO0,
   input  logic                  FLASH_IO1,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic [WORD_WIDTH-1:0] rom_data,
   output logic                  rom_load,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam int MAXBITS = (WORD_WIDTH > 24) ? WORD_WIDTH : 24;
   localparam int CW      = $clog2(MAXBITS);
   localparam int DW      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int GW      = $clog2(2 * SCK_DIV);
   localparam int LW      = ADDR_WIDTH + 1;

   typedef enum logic [3:0] {
      IDLE,
      CMD,
      ADDR,
      HDR,
      DATA,
`ifdef BOOT_CHECKSUM_EN
      CSUM,
`endif
      FINISH,
      DONE,
      ERROR
   } state_t;

`ifdef BOOT_CHECKSUM_EN
   localparam state_t POST_DATA = CSUM;
`else
   localparam state_t POST_DATA = FINISH;
`endif

   state_t                r_state;
   state_t                w_nextState;
   logic [DW-1:0]         r_divCnt;
   logic                  r_sck;
   logic [CW-1:0]         r_bitCnt;
   logic [31:0]           r_txShift;
   logic [WORD_WIDTH-2:0] r_rxShift;
   logic [LW-1:0]         r_len;
   logic [LW-1:0]         r_wordCnt;
   logic                  r_fail;
   logic                  r_startD;
   logic                  r_romLoad;
   logic [ADDR_WIDTH-1:0] r_romAddr;
   logic [WORD_WIDTH-1:0] r_romData;
   logic [GW-1:0]         r_guardCnt;
`ifdef BOOT_CHECKSUM_EN
   logic [WORD_WIDTH-1:0] r_sum;
`endif

   logic                  w_shifting;
   logic                  w_tick;
   logic                  w_rise;
   logic                  w_fall;
   logic                  w_phaseEnd;
   logic                  w_lastBit;
   logic                  w_lastWord;
   logic                  w_startRise;
   logic                  w_lenTooBig;
   logic [CW-1:0]         w_phaseLast;
   logic [WORD_WIDTH-1:0] w_rxWord;

   // The SPI clock only runs while a shifting phase is active; each phase has its own bit length.
   always_comb begin
      w_shifting  = 1'b0;
      w_phaseLast = CW'(WORD_WIDTH - 1);
      case (r_state)
         CMD: begin
            w_shifting  = 1'b1;
            w_phaseLast = CW'(7);
         end
         ADDR: begin
            w_shifting  = 1'b1;
            w_phaseLast = CW'(23);
         end
         HDR:  w_shifting = 1'b1;
         DATA: w_shifting = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         CSUM: w_shifting = 1'b1;
`endif
         default: w_shifting = 1'b0;
      endcase
   end

   assign w_tick      = w_shifting && (r_divCnt == DW'(SCK_DIV - 1));
   assign w_rise      = w_tick && !r_sck;
   assign w_fall      = w_tick && r_sck;
   assign w_lastBit   = (r_bitCnt == w_phaseLast);
   assign w_phaseEnd  = w_fall && w_lastBit;
   assign w_lastWord  = ((r_wordCnt + LW'(1)) == r_len);
   assign w_startRise = start && !r_startD;
   assign w_rxWord    = {r_rxShift, FLASH_IO1};
   assign w_lenTooBig = ({{LW{1'b0}}, w_rxWord} > {{WORD_WIDTH{1'b0}}, 1'b1, {ADDR_WIDTH{1'b0}}});

   assign FLASH_SCK = r_sck;
   assign FLASH_IO0 = r_txShift[31];
   assign rom_load  = r_romLoad;
   assign rom_addr  = r_romAddr;
   assign rom_data  = r_romData;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Phase changes happen only on a falling SCK edge, so a DATA write pulse always lands inside DATA.
   always_comb begin
      w_nextState = r_state;
      busy        = 1'b1;
      cpu_hold    = 1'b1;
      done        = 1'b0;
      error       = 1'b0;
      FLASH_SSB   = 1'b0;
      case (r_state)
         IDLE: begin
            busy        = 1'b0;
            FLASH_SSB   = 1'b1;
            w_nextState = CMD;
         end
         CMD:  if (w_phaseEnd) w_nextState = ADDR;
         ADDR: if (w_phaseEnd) w_nextState = HDR;
         HDR: begin
            if (w_phaseEnd) begin
               if (r_fail) begin
                  w_nextState = FINISH;
               end else if (r_len == '0) begin
                  w_nextState = POST_DATA;
               end else begin
                  w_nextState = DATA;
               end
            end
         end
         DATA: if (w_phaseEnd && w_lastWord) w_nextState = POST_DATA;
`ifdef BOOT_CHECKSUM_EN
         CSUM: if (w_phaseEnd) w_nextState = FINISH;
`endif
         FINISH: begin
            FLASH_SSB = 1'b1;
            if (r_guardCnt == GW'(2 * SCK_DIV - 1)) begin
               w_nextState = r_fail ? ERROR : DONE;
            end
         end
         DONE: begin
            busy      = 1'b0;
            cpu_hold  = 1'b0;
            done      = 1'b1;
            FLASH_SSB = 1'b1;
            if (w_startRise) w_nextState = CMD;
         end
         ERROR: begin
            busy      = 1'b0;
            error     = 1'b1;
            FLASH_SSB = 1'b1;
            if (w_startRise) w_nextState = CMD;
         end
         default: begin
            busy        = 1'b0;
            FLASH_SSB   = 1'b1;
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_divCnt   <= '0;
         r_sck      <= 1'b0;
         r_bitCnt   <= '0;
         r_txShift  <= '0;
         r_rxShift  <= '0;
         r_len      <= '0;
         r_wordCnt  <= '0;
         r_fail     <= 1'b0;
         r_startD   <= 1'b0;
         r_romLoad  <= 1'b0;
         r_romAddr  <= '0;
         r_romData  <= '0;
         r_guardCnt <= '0;
`ifdef BOOT_CHECKSUM_EN
         r_sum      <= '0;
`endif
      end else begin
         r_startD  <= start;
         r_romLoad <= 1'b0;

         if (w_shifting) begin
            if (w_tick) begin
               r_divCnt <= '0;
               r_sck    <= ~r_sck;
            end else begin
               r_divCnt <= r_divCnt + DW'(1);
            end
         end else begin
            r_divCnt <= '0;
            r_sck    <= 1'b0;
         end

         // MISO is captured on the rising edge; a completed word is acted on in the same edge.
         if (w_rise) begin
            r_rxShift <= w_rxWord[WORD_WIDTH-2:0];
            if (w_lastBit) begin
               case (r_state)
                  HDR: begin
                     r_len  <= LW'(w_rxWord);
                     r_fail <= w_lenTooBig;
`ifdef BOOT_CHECKSUM_EN
                     r_sum  <= w_rxWord;
`endif
                  end
                  DATA: begin
                     r_romLoad <= 1'b1;
                     r_romAddr <= r_wordCnt[ADDR_WIDTH-1:0];
                     r_romData <= w_rxWord;
`ifdef BOOT_CHECKSUM_EN
                     r_sum     <= r_sum + w_rxWord;
`endif
                  end
`ifdef BOOT_CHECKSUM_EN
                  CSUM: if ((r_sum + w_rxWord) != '0) r_fail <= 1'b1;
`endif
                  default: ;
               endcase
            end
         end

         if (w_fall) begin
            r_txShift <= {r_txShift[30:0], 1'b0};
            if (w_lastBit) begin
               r_bitCnt <= '0;
               if (r_state == DATA) r_wordCnt <= r_wordCnt + LW'(1);
            end else begin
               r_bitCnt <= r_bitCnt + CW'(1);
            end
         end

         if (r_state == FINISH) begin
            r_guardCnt <= r_guardCnt + GW'(1);
         end else begin
            r_guardCnt <= '0;
         end

         // Every boot restarts from the header: command, address and counters are reloaded.
         if ((w_nextState == CMD) && (r_state != CMD)) begin
            r_txShift <= {8'h03, FLASH_BASE};
            r_bitCnt  <= '0;
            r_wordCnt <= '0;
            r_len     <= '0;
            r_fail    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed checks of boot_loader against a behavioural SPI flash model
// serving a length header, data words and a trailing checksum word (read only when checksums are enabled).
module tb_boot_loader;
   logic        CLK       = 1'b0;
   logic        RST_N     = 1'b0;
   logic        start     = 1'b0;
   logic        FLASH_IO1 = 1'b0;
   logic        FLASH_SCK;
   logic        FLASH_SSB;
   logic        FLASH_IO0;
   logic [13:0] rom_addr;
   logic [15:0] rom_data;
   logic        rom_load;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   logic [15:0] img [16];
   int          flRise = 0;
   logic [31:0] flCmd  = '0;

   int          loadCnt    = 0;
   logic [13:0] loadAddr [64];
   logic [15:0] loadData [64];
   int          ssbHighCnt = 0;
   int          ssbAtDone  = 0;
   int          ioViol     = 0;
   logic        prevDone   = 1'b0;
   logic        prevIo0    = 1'b0;

   boot_loader dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (start),
      .FLASH_SCK (FLASH_SCK),
      .FLASH_SSB (FLASH_SSB),
      .FLASH_IO0 (FLASH_IO0),
      .FLASH_IO1 (FLASH_IO1),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rom_load  (rom_load),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 CLK = ~CLK;

   function automatic logic imageBit(input int idx);
      int w;
      w = idx / 16;
      if (w >= 16) return 1'b0;
      return img[w][15 - (idx % 16)];
   endfunction

   // Flash model: 32 command/address bits in, then the image streamed out MSB first on falling SCK.
   always @(negedge FLASH_SSB) flRise = 0;

   always @(posedge FLASH_SCK) begin
      if (FLASH_SSB === 1'b0) begin
         if (flRise < 32) flCmd = {flCmd[30:0], FLASH_IO0};
         flRise = flRise + 1;
      end
   end

   always @(negedge FLASH_SCK) begin
      if (FLASH_SSB === 1'b0 && flRise >= 32) FLASH_IO1 = imageBit(flRise - 32);
   end

   // Observers sample on the falling CLK edge, away from the design's active edge.
   always @(negedge CLK) begin
      if (rom_load === 1'b1) begin
         if (loadCnt < 64) begin
            loadAddr[loadCnt] = rom_addr;
            loadData[loadCnt] = rom_data;
         end
         loadCnt = loadCnt + 1;
      end
      if (done === 1'b1 && prevDone !== 1'b1) ssbAtDone = ssbHighCnt;
      ssbHighCnt = (FLASH_SSB === 1'b1) ? ssbHighCnt + 1 : 0;
      if (FLASH_SSB === 1'b0 && FLASH_SCK === 1'b1 && FLASH_IO0 !== prevIo0) ioViol = ioViol + 1;
      prevIo0  = FLASH_IO0;
      prevDone = done;
   end

   task automatic computeChecksum(input int nData);
      logic [15:0] sum;
      sum = '0;
      for (int i = 0; i <= nData; i++) sum = sum + img[i];
      img[nData + 1] = 16'h0000 - sum;
   endtask

   task automatic applyStimulus();
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic waitEnd(output bit ok);
      int n;
      n = 0;
      while (!((done === 1'b1 || error === 1'b1) && busy === 1'b0) && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      ok = (n < 5000);
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if ({FLASH_SSB, FLASH_SCK, FLASH_IO0, rom_load, cpu_hold, busy, done, error} !== 8'b1000_1000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 10001000 (ssb,sck,io0,load,hold,busy,done,err)",
                  {FLASH_SSB, FLASH_SCK, FLASH_IO0, rom_load, cpu_hold, busy, done, error});
      end
      checks++;
      if (rom_addr !== 14'd0) begin
         errors++;
         $display("[TB] FAIL reset_addr: got %h expected 0", rom_addr);
      end
      checks++;
      if (rom_data !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h expected 0", rom_data);
      end
   endtask

   task automatic test_basic_load();
      logic [15:0] expData [3] = '{16'h0001, 16'h00FF, 16'hA5A5};
      int base;
      int expRise;
      bit ok;
      img[0] = 16'd3;
      for (int i = 0; i < 3; i++) img[i + 1] = expData[i];
      computeChecksum(3);
`ifdef BOOT_CHECKSUM_EN
      expRise = 32 + 16 + 48 + 16;
`else
      expRise = 32 + 16 + 48;
`endif
      base  = loadCnt;
      RST_N = 1'b1;
      @(negedge CLK);
      checks++;
      if ({FLASH_SSB, busy, cpu_hold} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL boot_after_reset: ssb,busy,hold got %b expected 011", {FLASH_SSB, busy, cpu_hold});
      end
      waitEnd(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL basic_timeout: got no done/error expected done within 5000 cycles");
      end
      checks++;
      if (loadCnt - base !== 3) begin
         errors++;
         $display("[TB] FAIL basic_count: got %0d loads expected 3", loadCnt - base);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (loadAddr[base + i] !== 14'(i) || loadData[base + i] !== expData[i]) begin
            errors++;
            $display("[TB] FAIL basic_word%0d: got addr %0d data %h expected addr %0d data %h",
                     i, loadAddr[base + i], loadData[base + i], i, expData[i]);
         end
      end
      checks++;
      if ({done, error, cpu_hold, busy, FLASH_SSB, FLASH_SCK} !== 6'b100010) begin
         errors++;
         $display("[TB] FAIL basic_done: done,err,hold,busy,ssb,sck got %b expected 100010",
                  {done, error, cpu_hold, busy, FLASH_SSB, FLASH_SCK});
      end
      checks++;
      if (flCmd !== 32'h03100000) begin
         errors++;
         $display("[TB] FAIL cmd_bits: got %h expected 03100000", flCmd);
      end
      checks++;
      if (ioViol !== 0) begin
         errors++;
         $display("[TB] FAIL io0_stable: got %0d changes while SCK high expected 0", ioViol);
      end
      checks++;
      if (flRise !== expRise) begin
         errors++;
         $display("[TB] FAIL basic_sck_edges: got %0d expected %0d", flRise, expRise);
      end
   endtask

   task automatic test_zero_length();
      int base;
      int expRise;
      bit ok;
      img[0] = 16'd0;
      computeChecksum(0);
`ifdef BOOT_CHECKSUM_EN
      expRise = 32 + 16 + 16;
`else
      expRise = 32 + 16;
`endif
      base = loadCnt;
      applyStimulus();
      checks++;
      if ({cpu_hold, busy, done} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL reboot_hold: hold,busy,done got %b expected 110", {cpu_hold, busy, done});
      end
      waitEnd(ok);
      checks++;
      if (!ok || done !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_done: got done %b error %b expected done 1 error 0", done, error);
      end
      checks++;
      if (loadCnt - base !== 0) begin
         errors++;
         $display("[TB] FAIL zero_count: got %0d loads expected 0", loadCnt - base);
      end
      checks++;
      if (ssbAtDone < 4) begin
         errors++;
         $display("[TB] FAIL zero_ssb_guard: got %0d cycles SSB high before done expected >= 4", ssbAtDone);
      end
      checks++;
      if (flRise !== expRise) begin
         errors++;
         $display("[TB] FAIL zero_sck_edges: got %0d expected %0d", flRise, expRise);
      end
   endtask

   task automatic test_too_long();
      int base;
      bit ok;
      img[0] = 16'd16385;
      base   = loadCnt;
      applyStimulus();
      waitEnd(ok);
      checks++;
      if (!ok || {error, cpu_hold, done, busy} !== 4'b1100) begin
         errors++;
         $display("[TB] FAIL toolong_state: err,hold,done,busy got %b expected 1100", {error, cpu_hold, done, busy});
      end
      checks++;
      if (loadCnt - base !== 0) begin
         errors++;
         $display("[TB] FAIL toolong_count: got %0d loads expected 0", loadCnt - base);
      end
      checks++;
      if (flRise !== 48) begin
         errors++;
         $display("[TB] FAIL toolong_sck_edges: got %0d expected 48", flRise);
      end
   endtask

   task automatic test_reset_mid_load();
      int base;
      int n;
      bit ok;
      img[0] = 16'd3;
      img[1] = 16'h0001;
      img[2] = 16'h00FF;
      img[3] = 16'hA5A5;
      computeChecksum(3);
      base = loadCnt;
      applyStimulus();
      n = 0;
      while (loadCnt - base < 1 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      repeat (20) @(negedge CLK);
      #1 RST_N = 1'b0;
      #1;
      checks++;
      if ({FLASH_SSB, busy, cpu_hold, rom_load} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL midreset_abort: ssb,busy,hold,load got %b expected 1010",
                  {FLASH_SSB, busy, cpu_hold, rom_load});
      end
      checks++;
      if (loadCnt - base !== 1) begin
         errors++;
         $display("[TB] FAIL midreset_partial: got %0d loads before reset expected 1", loadCnt - base);
      end
      repeat (3) @(negedge CLK);
      base  = loadCnt;
      RST_N = 1'b1;
      waitEnd(ok);
      checks++;
      if (!ok || done !== 1'b1 || loadCnt - base !== 3) begin
         errors++;
         $display("[TB] FAIL midreset_reload: got done %b loads %0d expected done 1 loads 3", done, loadCnt - base);
      end
      checks++;
      if (loadAddr[base] !== 14'd0 || loadData[base] !== 16'h0001 ||
          loadAddr[base + 2] !== 14'd2 || loadData[base + 2] !== 16'hA5A5) begin
         errors++;
         $display("[TB] FAIL midreset_words: got %0d:%h %0d:%h expected 0:0001 2:a5a5",
                  loadAddr[base], loadData[base], loadAddr[base + 2], loadData[base + 2]);
      end
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_checksum();
      int base;
      bit ok;
      img[0] = 16'd2;
      img[1] = 16'h0010;
      img[2] = 16'h0020;
      img[3] = 16'hFFCE;
      base   = loadCnt;
      applyStimulus();
      waitEnd(ok);
      checks++;
      if (!ok || done !== 1'b1 || error !== 1'b0 || loadCnt - base !== 2) begin
         errors++;
         $display("[TB] FAIL csum_good: got done %b error %b loads %0d expected 1 0 2", done, error, loadCnt - base);
      end
      img[3] = 16'hFFCF;
      applyStimulus();
      waitEnd(ok);
      checks++;
      if (!ok || {error, done, cpu_hold} !== 3'b101) begin
         errors++;
         $display("[TB] FAIL csum_bad: err,done,hold got %b expected 101", {error, done, cpu_hold});
      end
      img[3] = 16'hFFCE;
      applyStimulus();
      waitEnd(ok);
      checks++;
      if (!ok || done !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL csum_retry: got done %b error %b expected done 1 error 0", done, error);
      end
   endtask
`endif

   initial begin
      $display("[TB] boot_loader directed test starting");
      test_reset();
      test_basic_load();
      test_zero_length();
      test_too_long();
      test_reset_mid_load();
`ifdef BOOT_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
